// File: rtl/xs_start_conditioner.sv
// Button front-end for the SD start input: synchronise, debounce, one xs pulse per press, lock out until fin.
// Latency: btn_raw_i steady before edge 1 gives btn_level_o after edge N+2 and xs_o for the one cycle after edge N+3.
// Backpressure: no handshake; presses arriving while busy_o=1 are dropped, never queued.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   btn_raw_i    raw asynchronous push-button, 1 = pressed
//   fin_i        completion flag from SD, level or pulse, sampled every cycle
//   xs_o         single-cycle start pulse to SD
//   btn_level_o  debounced button level
//   busy_o       high from the xs_o cycle until fin_i has been seen
module xs_start_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    input  logic fin_i,
    output logic xs_o,
    output logic btn_level_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

    // Two-flop synchroniser; s1 feeds nothing but s2.
    logic s1_q;
    logic s2_q;

    // Debouncer
    logic             lvl_q;
    logic             lvl_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Rising-edge detect on the debounced level
    logic lvl_dly_q;
    logic press;

    // Control FSM with registered outputs
    state_e state_q;
    state_e state_d;
    logic   xs_q;
    logic   xs_d;
    logic   busy_q;
    logic   busy_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_raw_i;
            s2_q <= s1_q;
        end
    end

    // The counter tracks how many consecutive samples have disagreed with the
    // accepted level; any agreeing sample restarts the qualification.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            lvl_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lvl_q     <= 1'b0;
            cnt_q     <= '0;
            lvl_dly_q <= 1'b0;
        end else begin
            lvl_q     <= lvl_d;
            cnt_q     <= cnt_d;
            lvl_dly_q <= lvl_q;
        end
    end

    // Only the 0->1 transition of the debounced level counts as a press.
    assign press = lvl_q & ~lvl_dly_q;

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            xs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            busy_q  <= busy_d;
        end
    end

    // Next state. FIRE always lasts one cycle so fin in that cycle cannot
    // cut the lock-out short; a press coinciding with fin in BUSY is dropped.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = press ? ST_FIRE : ST_IDLE;
            ST_FIRE: state_d = ST_BUSY;
            ST_BUSY: state_d = fin_i ? ST_IDLE : ST_BUSY;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so xs_o and
    // busy_o change exactly with the state register and never glitch.
    always_comb begin
        xs_d   = 1'b0;
        busy_d = 1'b0;
        case (state_d)
            ST_FIRE: begin
                xs_d   = 1'b1;
                busy_d = 1'b1;
            end
            ST_BUSY: busy_d = 1'b1;
            default: begin
                xs_d   = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign xs_o        = xs_q;
    assign busy_o      = busy_q;
    assign btn_level_o = lvl_q;

endmodule

// File: tb/tb_xs_start_conditioner.sv
module tb_xs_start_conditioner;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_raw;
    logic fin;
    logic xs;
    logic btn_level;
    logic busy;

    always #5 clk = ~clk;

    xs_start_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (3)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .btn_raw_i  (btn_raw),
        .fin_i      (fin),
        .xs_o       (xs),
        .btn_level_o(btn_level),
        .busy_o     (busy)
    );

    // ------------------------------------------------------------------
    // Reference model: sampled-history view of the button plus a
    // "locked / firing" view of the start handshake.
    // ------------------------------------------------------------------
    typedef struct {
        bit xs;
        bit busy;
        bit lvl;
    } exp_t;

    exp_t exp_q[$];
    bit   pipe[2];      // raw button delayed by two clock samples
    bit   hist[$];      // last N synchronised samples
    bit   m_lvl;
    bit   m_lvl_prev;
    bit   m_locked;
    bit   m_firing;
    int   cyc = 0;

    function automatic void model_reset();
        pipe[0]    = 1'b0;
        pipe[1]    = 1'b0;
        hist.delete();
        m_lvl      = 1'b0;
        m_lvl_prev = 1'b0;
        m_locked   = 1'b0;
        m_firing   = 1'b0;
    endfunction

    always @(posedge clk) begin : model_step
        exp_t e;
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin : model_run
            bit synced;
            bit pressed;
            bit flip;
            synced  = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = btn_raw;
            pressed    = m_lvl && !m_lvl_prev;
            m_lvl_prev = m_lvl;
            // Accept a new level once N consecutive samples all disagree with it.
            hist.push_back(synced);
            if (hist.size() > N) void'(hist.pop_front());
            flip = (hist.size() == N);
            foreach (hist[i]) if (hist[i] == m_lvl) flip = 1'b0;
            if (flip) m_lvl = !m_lvl;
            if (m_firing) begin
                m_firing = 1'b0;
            end else if (m_locked) begin
                if (fin) m_locked = 1'b0;
            end else if (pressed) begin
                m_firing = 1'b1;
                m_locked = 1'b1;
            end
        end
        e.xs   = m_firing;
        e.busy = m_locked;
        e.lvl  = m_lvl;
        exp_q.push_back(e);
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks    = 0;
    int n_pass      = 0;
    int xs_count    = 0;
    int last_xs_cyc = -1;
    bit lvl_seen    = 1'b0;

    task automatic check(input string name, input logic act, input logic exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp_v);
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    endtask

    // Monitor: pops one expectation for every cycle the DUT presents.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (xs === 1'b1) begin
            xs_count++;
            last_xs_cyc = cyc;
        end
        if (btn_level === 1'b1) lvl_seen = 1'b1;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_underflow at cycle %0d: got empty queue, expected an entry", cyc);
        end else begin
            e = exp_q.pop_front();
            check("sb_xs", xs, e.xs);
            check("sb_busy", busy, e.busy);
            check("sb_btn_level", btn_level, e.lvl);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after the falling edge.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic settle();
        btn_raw = 1'b0;
        fin     = 1'b0;
        step(10);
        fin = 1'b1;
        step(1);
        fin = 1'b0;
        step(2);
    endtask

    int start;
    int base;
    int hold;

    initial begin
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        fin     = 1'b0;
        model_reset();
        step(3);
        check("reset_xs", xs, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_btn_level", btn_level, 1'b0);
        rst_n = 1'b1;
        step(3);

        // 1: clean press
        base    = xs_count;
        btn_raw = 1'b1;
        start   = cyc;
        step(5);
        check("clean_lvl_before_edge6", btn_level, 1'b0);
        step(1);
        check("clean_lvl_after_edge6", btn_level, 1'b1);
        check("clean_xs_before_edge7", xs, 1'b0);
        step(1);
        check("clean_xs_after_edge7", xs, 1'b1);
        check("clean_busy_after_edge7", busy, 1'b1);
        step(1);
        check("clean_xs_one_cycle", xs, 1'b0);
        check("clean_busy_held", busy, 1'b1);
        step(20);
        check_int("clean_xs_count_hold", xs_count - base, 1);

        // 2: bounce then steady press
        settle();
        base = xs_count;
        for (int i = 0; i < 10; i++) begin
            btn_raw = (i % 2 == 0);
            step(1);
        end
        check_int("bounce_no_xs", xs_count - base, 0);
        btn_raw = 1'b1;
        start   = cyc;
        step(12);
        check_int("bounce_xs_count", xs_count - base, 1);
        check_int("bounce_xs_delay", last_xs_cyc - start, 7);

        // 3: short glitch is rejected
        settle();
        base     = xs_count;
        lvl_seen = 1'b0;
        btn_raw  = 1'b1;
        step(3);
        btn_raw = 1'b0;
        step(10);
        check("glitch_lvl_never", lvl_seen, 1'b0);
        check_int("glitch_no_xs", xs_count - base, 0);

        // 4: lock-out until fin, then a new press fires
        settle();
        base    = xs_count;
        btn_raw = 1'b1;
        start   = cyc;
        step(8);
        check_int("lock_first_xs", xs_count - base, 1);
        check_int("lock_first_delay", last_xs_cyc - start, 7);
        btn_raw = 1'b0;
        step(8);
        btn_raw = 1'b1;
        step(10);
        check_int("lock_second_dropped", xs_count - base, 1);
        check("lock_busy_held", busy, 1'b1);
        fin = 1'b1;
        step(1);
        fin = 1'b0;
        check("lock_busy_released", busy, 1'b0);
        btn_raw = 1'b0;
        step(8);
        btn_raw = 1'b1;
        start   = cyc;
        step(10);
        check_int("lock_third_xs", xs_count - base, 2);
        check_int("lock_third_delay", last_xs_cyc - start, 7);

        // 5: press and fin in the same cycle while busy
        settle();
        btn_raw = 1'b1;
        step(10);
        btn_raw = 1'b0;
        step(8);
        base    = xs_count;
        btn_raw = 1'b1;
        step(6);
        fin = 1'b1;
        step(1);
        fin = 1'b0;
        check("collide_busy_released", busy, 1'b0);
        step(6);
        check_int("collide_no_xs", xs_count - base, 0);
        check("collide_still_idle", busy, 1'b0);

        // 6: asynchronous reset while busy with the debounce counter running
        settle();
        btn_raw = 1'b1;
        step(10);
        btn_raw = 1'b0;
        step(4);
        check("midop_busy_before", busy, 1'b1);
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        #1;
        check("midop_rst_xs", xs, 1'b0);
        check("midop_rst_busy", busy, 1'b0);
        check("midop_rst_lvl", btn_level, 1'b0);
        model_reset();
        exp_q.delete();
        exp_q.push_back('{xs: 1'b0, busy: 1'b0, lvl: 1'b0});
        step(2);
        rst_n = 1'b1;
        base  = xs_count;
        start = cyc;
        step(10);
        check_int("midop_xs_count", xs_count - base, 1);
        check_int("midop_xs_delay", last_xs_cyc - start, 7);

        // Random traffic against the model
        settle();
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                btn_raw = 1'($urandom_range(0, 1));
                hold    = $urandom_range(1, 12);
            end
            fin = ($urandom_range(0, 7) == 0);
            step(1);
            hold--;
        end
        fin     = 1'b0;
        btn_raw = 1'b0;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
